// File: rtl/vram_ctrl.sv
// vram_ctrl: sequences RAS/CAS access cycles to a video RAM for byte reads,
// byte writes and read transfers, and generates the serial clock/enable.
module vram_ctrl #(
    parameter int unsigned TCAS = 3,
    parameter int unsigned TPRE = 2
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic        xfer_req,
    input  logic [15:0] xfer_addr,
    input  logic        rd_req,
    input  logic [15:0] rd_addr,
    input  logic        wr_req,
    input  logic [15:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        xfer_ack,
    output logic        rd_ack,
    output logic        wr_ack,
    output logic [7:0]  rd_data,
    input  logic        sc_step,
    input  logic        ser_en,
    output logic        busy,
    output logic        RAS,
    output logic        CAS,
    output logic        WE,
    output logic        OE,
    output logic        SC,
    output logic        SE,
    output logic [7:0]  AD,
    output logic [7:0]  RD_o,
    output logic        RD_d,
    input  logic [7:0]  RD_i
);

    typedef enum logic [1:0] {IDLE, ROW, COL, PRE} state_t;
    typedef enum logic [1:0] {OP_XFER, OP_RD, OP_WR} op_t;

    localparam logic [2:0] ROW_LAST = 3'd1;
    localparam logic [2:0] COL_LAST = 3'(TCAS - 1);
    localparam logic [2:0] PRE_LAST = 3'(TPRE - 1);

    state_t      state_q, state_d;
    logic [2:0]  phase_q, phase_d;
    op_t         op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        sc_q, sc_d;
    logic        se_q, se_d;
    logic        wr_block_q, wr_block_d;

    // State, latched request and serial-control registers
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            op_q       <= OP_XFER;
            addr_q     <= '0;
            data_q     <= '0;
            rd_data_q  <= '0;
            sc_q       <= 1'b0;
            se_q       <= 1'b1;
            wr_block_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            sc_q       <= sc_d;
            se_q       <= se_d;
            wr_block_q <= wr_block_d;
        end
    end

    // Arbitration, phase sequencing and read-data capture
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (xfer_req) begin
                    state_d = ROW;
                    op_d    = OP_XFER;
                    addr_d  = xfer_addr;
                end else if (rd_req) begin
                    state_d = ROW;
                    op_d    = OP_RD;
                    addr_d  = rd_addr;
                end else if (wr_req && !wr_block_q) begin
                    state_d = ROW;
                    op_d    = OP_WR;
                    addr_d  = wr_addr;
                    data_d  = wr_data;
                end
            end
            ROW: begin
                if (phase_q == ROW_LAST) begin
                    state_d = COL;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            COL: begin
                if (phase_q == COL_LAST) begin
                    state_d = PRE;
                    phase_d = '0;
                    if (op_q == OP_RD) begin
                        rd_data_d = RD_i;
                    end
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            PRE: begin
                if (phase_q == PRE_LAST) begin
                    state_d = IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // VRAM strobes, address mux and completion pulses decoded from state
    always_comb begin
        RAS      = 1'b1;
        CAS      = 1'b1;
        WE       = 1'b1;
        OE       = 1'b1;
        RD_d     = 1'b1;
        AD       = '0;
        RD_o     = '0;
        xfer_ack = 1'b0;
        rd_ack   = 1'b0;
        wr_ack   = 1'b0;
        case (state_q)
            ROW: begin
                RAS = 1'b0;
                AD  = addr_q[15:8];
                OE  = (op_q != OP_XFER);
            end
            COL: begin
                RAS = 1'b0;
                CAS = 1'b0;
                AD  = addr_q[7:0];
                if (op_q == OP_WR) begin
                    WE   = 1'b0;
                    RD_d = 1'b0;
                    RD_o = data_q;
                end else begin
                    OE = 1'b0;
                end
            end
            PRE: begin
                if (phase_q == '0) begin
                    xfer_ack = (op_q == OP_XFER);
                    rd_ack   = (op_q == OP_RD);
                    wr_ack   = (op_q == OP_WR);
                end
            end
            default: ;
        endcase
    end

    // Serial clock pulse, registered serial enable and write re-arm tracking
    always_comb begin
        sc_d = sc_step & ~sc_q;
        se_d = ~ser_en;
        // A served write stays blocked until its request is seen low.
        wr_block_d = (wr_block_q & wr_req) | wr_ack;
    end

    assign rd_data = rd_data_q;
    assign SC      = sc_q;
    assign SE      = se_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_vram_ctrl.sv
// tb_vram_ctrl: randomized self-checking bench for vram_ctrl with a
// behavioural VRAM model and a byte scoreboard.
module tb_vram_ctrl;

    localparam int TCAS = 3;
    localparam int TPRE = 2;
    localparam int CYC  = 3 + TCAS + TPRE;
    localparam int KACK = 3 + TCAS;

    typedef enum int {OP_XF, OP_RD, OP_WR} tb_op_t;

    logic        MCLK      = 1'b0;
    logic        reset     = 1'b0;
    logic        xfer_req  = 1'b0;
    logic [15:0] xfer_addr = '0;
    logic        rd_req    = 1'b0;
    logic [15:0] rd_addr   = '0;
    logic        wr_req    = 1'b0;
    logic [15:0] wr_addr   = '0;
    logic [7:0]  wr_data   = '0;
    logic        sc_step   = 1'b0;
    logic        ser_en    = 1'b0;
    logic        xfer_ack, rd_ack, wr_ack, busy;
    logic [7:0]  rd_data, AD, RD_o, RD_i;
    logic        RAS, CAS, WE, OE, SC, SE, RD_d;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 MCLK = ~MCLK;

    vram_ctrl #(.TCAS(TCAS), .TPRE(TPRE)) dut (
        .MCLK(MCLK), .reset(reset),
        .xfer_req(xfer_req), .xfer_addr(xfer_addr),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .xfer_ack(xfer_ack), .rd_ack(rd_ack), .wr_ack(wr_ack),
        .rd_data(rd_data), .sc_step(sc_step), .ser_en(ser_en), .busy(busy),
        .RAS(RAS), .CAS(CAS), .WE(WE), .OE(OE), .SC(SC), .SE(SE),
        .AD(AD), .RD_o(RD_o), .RD_d(RD_d), .RD_i(RD_i)
    );

    // ---------------- VRAM model ----------------
    logic [7:0] vmem   [0:65535];
    bit         vvalid [0:65535];
    logic [7:0] m_row = '0, m_col = '0, rd_i_r = '0;
    logic       m_dt = 1'b0;
    logic [7:0] sam [0:3];
    logic [1:0] sptr = '0;
    logic       p_ras = 1'b1, p_cas = 1'b1, p_oe = 1'b1, p_sc = 1'b0;
    int         cas_cnt = 0;
    logic [7:0] ser_q [$];

    assign RD_i = rd_i_r;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] vm_rd(input logic [15:0] a);
        return vvalid[a] ? vmem[a] : init_byte(a);
    endfunction

    // Strobe-driven memory: row on RAS fall, column/write on CAS fall,
    // data valid only in the last column cycle, transfer on OE rise.
    always @(negedge MCLK) begin
        p_ras <= RAS;
        p_cas <= CAS;
        p_oe  <= OE;
        p_sc  <= SC;
        if (p_ras && !RAS) begin
            m_row <= AD;
            m_dt  <= !OE;
        end
        if (!CAS) cas_cnt <= cas_cnt + 1;
        else      cas_cnt <= 0;
        if (p_cas && !CAS) begin
            m_col <= AD;
            if (!WE) begin
                vmem[{m_row, AD}]   <= RD_o;
                vvalid[{m_row, AD}] <= 1'b1;
            end
        end
        if (!CAS && !OE && cas_cnt == TCAS - 1) rd_i_r <= vm_rd({m_row, m_col});
        else                                    rd_i_r <= 8'h00;
        if (!p_oe && OE && m_dt) begin
            for (int i = 0; i < 4; i++) sam[i] <= vm_rd({m_row, m_col[7:2], 2'(i)});
            sptr <= m_col[1:0];
            m_dt <= 1'b0;
        end
        if (SC && !p_sc) begin
            if (!SE) ser_q.push_back(sam[sptr]);
            sptr <= sptr + 2'd1;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] sb [logic [15:0]];

    function automatic logic [7:0] sb_rd(input logic [15:0] a);
        return sb.exists(a) ? sb[a] : init_byte(a);
    endfunction

    // Expected {busy,RAS,CAS,WE,OE,RD_d,AD,xfer_ack,rd_ack,wr_ack} k cycles
    // after the IDLE cycle in which the request was accepted.
    function automatic logic [14:0] exp_v(input int k, input tb_op_t op, input logic [15:0] a);
        logic bz, ras, cas, we, oe, rdd, xa, ra, wa;
        logic [7:0] ad;
        bz = 0; ras = 1; cas = 1; we = 1; oe = 1; rdd = 1; xa = 0; ra = 0; wa = 0; ad = 8'h00;
        if (k >= 1 && k <= 2) begin
            bz = 1; ras = 0; ad = a[15:8]; oe = (op == OP_XF) ? 1'b0 : 1'b1;
        end else if (k >= 3 && k <= 2 + TCAS) begin
            bz = 1; ras = 0; cas = 0; ad = a[7:0];
            if (op == OP_WR) begin we = 0; rdd = 0; end
            else oe = 0;
        end else if (k >= 3 + TCAS && k <= 2 + TCAS + TPRE) begin
            bz = 1;
            if (k == 3 + TCAS) begin
                xa = (op == OP_XF); ra = (op == OP_RD); wa = (op == OP_WR);
            end
        end
        return {bz, ras, cas, we, oe, rdd, ad, xa, ra, wa};
    endfunction

    function automatic logic [14:0] obs_now();
        return {busy, RAS, CAS, WE, OE, RD_d, AD, xfer_ack, rd_ack, wr_ack};
    endfunction

    logic [14:0] obs_v   [0:63];
    logic [7:0]  obs_rdo [0:63];
    logic [7:0]  obs_rdd [0:63];

    // Raise one request at the current (IDLE) negedge and record n cycles.
    task automatic run_cycle(input tb_op_t op, input logic [15:0] a, input logic [7:0] d,
                             input int n, input bit drop_on_ack);
        if (op == OP_XF) begin xfer_req = 1; xfer_addr = a; end
        else if (op == OP_RD) begin rd_req = 1; rd_addr = a; end
        else begin wr_req = 1; wr_addr = a; wr_data = d; end
        for (int k = 1; k <= n; k++) begin
            @(negedge MCLK);
            obs_v[k]   = obs_now();
            obs_rdo[k] = RD_o;
            obs_rdd[k] = rd_data;
            if (drop_on_ack) begin
                if (op == OP_XF && xfer_ack) xfer_req = 0;
                if (op == OP_RD && rd_ack)   rd_req = 0;
                if (op == OP_WR && wr_ack)   wr_req = 0;
            end
        end
        if (drop_on_ack) begin
            if (op == OP_XF) xfer_req = 0;
            else if (op == OP_RD) rd_req = 0;
            else wr_req = 0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [39:0] got, exp;
        reset = 1; sc_step = 1;
        repeat (2) @(negedge MCLK);
        got = {RAS, CAS, WE, OE, SC, SE, RD_d, AD, RD_o, rd_data, xfer_ack, rd_ack, wr_ack, busy, 6'd0};
        exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_state got=%h exp=%h", got, exp); end
        sc_step = 0;
        reset = 0;
        run_cycle(OP_RD, 16'h00FF, 8'h00, CYC, 1);
        for (int k = 1; k <= CYC; k++) begin
            n_checks++;
            if (obs_v[k] !== exp_v(k, OP_RD, 16'h00FF)) begin
                n_fail++; $display("FAIL first_arb k=%0d got=%h exp=%h", k, obs_v[k], exp_v(k, OP_RD, 16'h00FF));
            end
        end
        n_checks++;
        if (obs_rdd[KACK] !== init_byte(16'h00FF)) begin
            n_fail++; $display("FAIL first_arb_data got=%h exp=%h", obs_rdd[KACK], init_byte(16'h00FF));
        end
    endtask

    task automatic test_write_basic();
        sb[16'h1234] = 8'hA5;
        run_cycle(OP_WR, 16'h1234, 8'hA5, CYC, 1);
        for (int k = 1; k <= CYC; k++) begin
            n_checks++;
            if (obs_v[k] !== exp_v(k, OP_WR, 16'h1234)) begin
                n_fail++; $display("FAIL write_basic k=%0d got=%h exp=%h", k, obs_v[k], exp_v(k, OP_WR, 16'h1234));
            end
        end
        for (int k = 3; k <= 2 + TCAS; k++) begin
            n_checks++;
            if (obs_rdo[k] !== 8'hA5) begin
                n_fail++; $display("FAIL write_rdo k=%0d got=%h exp=a5", k, obs_rdo[k]);
            end
        end
    endtask

    task automatic test_read_back();
        run_cycle(OP_RD, 16'h1234, 8'h00, CYC, 1);
        for (int k = 1; k <= CYC; k++) begin
            n_checks++;
            if (obs_v[k] !== exp_v(k, OP_RD, 16'h1234)) begin
                n_fail++; $display("FAIL read_back k=%0d got=%h exp=%h", k, obs_v[k], exp_v(k, OP_RD, 16'h1234));
            end
        end
        n_checks++;
        if (obs_rdd[KACK] !== sb_rd(16'h1234)) begin
            n_fail++; $display("FAIL read_data got=%h exp=%h", obs_rdd[KACK], sb_rd(16'h1234));
        end
        n_checks++;
        if (obs_rdd[CYC] !== sb_rd(16'h1234)) begin
            n_fail++; $display("FAIL read_hold got=%h exp=%h", obs_rdd[CYC], sb_rd(16'h1234));
        end
    endtask

    task automatic test_priority();
        logic [15:0] xa, ra;
        logic [14:0] ev, ov;
        xa = 16'($urandom); ra = 16'($urandom);
        xfer_req = 1; xfer_addr = xa; rd_req = 1; rd_addr = ra;
        for (int k = 1; k <= 2 * CYC; k++) begin
            @(negedge MCLK);
            ov = obs_now();
            ev = (k <= CYC) ? exp_v(k, OP_XF, xa) : exp_v(k - CYC, OP_RD, ra);
            n_checks++;
            if (ov !== ev) begin
                n_fail++; $display("FAIL priority k=%0d got=%h exp=%h", k, ov, ev);
            end
            if (k == CYC + KACK) begin
                n_checks++;
                if (rd_data !== sb_rd(ra)) begin
                    n_fail++; $display("FAIL priority_rd_data got=%h exp=%h", rd_data, sb_rd(ra));
                end
            end
            if (xfer_ack) xfer_req = 0;
            if (rd_ack) rd_req = 0;
        end
        xfer_req = 0; rd_req = 0;
    endtask

    task automatic test_serial();
        logic [7:0]  d;
        logic [15:0] a;
        for (int j = 0; j < 4; j++) begin
            a = 16'h0100 + 16'(j);
            d = 8'($urandom);
            sb[a] = d;
            run_cycle(OP_WR, a, d, CYC, 1);
            n_checks++;
            if (obs_v[KACK] !== exp_v(KACK, OP_WR, a)) begin
                n_fail++; $display("FAIL serial_prefill j=%0d got=%h exp=%h", j, obs_v[KACK], exp_v(KACK, OP_WR, a));
            end
        end
        ser_q.delete();
        ser_en = 1;
        run_cycle(OP_XF, 16'h0102, 8'h00, CYC, 1);
        for (int k = 1; k <= CYC; k++) begin
            n_checks++;
            if (obs_v[k] !== exp_v(k, OP_XF, 16'h0102)) begin
                n_fail++; $display("FAIL xfer k=%0d got=%h exp=%h", k, obs_v[k], exp_v(k, OP_XF, 16'h0102));
            end
        end
        n_checks++;
        if (SE !== 1'b0) begin n_fail++; $display("FAIL se_level got=%b exp=0", SE); end
        for (int p = 0; p < 4; p++) begin
            sc_step = 1;
            @(negedge MCLK);
            n_checks++;
            if (SC !== 1'b1) begin n_fail++; $display("FAIL sc_pulse p=%0d got=%b exp=1", p, SC); end
            sc_step = 0;
            @(negedge MCLK);
            n_checks++;
            if (SC !== 1'b0) begin n_fail++; $display("FAIL sc_width p=%0d got=%b exp=0", p, SC); end
        end
        @(negedge MCLK);
        n_checks++;
        if (ser_q.size() != 4) begin
            n_fail++; $display("FAIL serial_count got=%0d exp=4", ser_q.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                a = {14'h0040, 2'(j + 2)};
                n_checks++;
                if (ser_q[j] !== sb_rd(a)) begin
                    n_fail++; $display("FAIL serial_byte j=%0d got=%h exp=%h", j, ser_q[j], sb_rd(a));
                end
            end
        end
        ser_en = 0;
    endtask

    task automatic test_write_lockout();
        logic [15:0] a;
        logic [7:0]  d;
        a = 16'($urandom); d = 8'($urandom);
        sb[a] = d;
        run_cycle(OP_WR, a, d, CYC + 4, 0);
        for (int k = 1; k <= CYC + 4; k++) begin
            n_checks++;
            if (obs_v[k] !== exp_v(k, OP_WR, a)) begin
                n_fail++; $display("FAIL lockout k=%0d got=%h exp=%h", k, obs_v[k], exp_v(k, OP_WR, a));
            end
        end
        wr_req = 0;
        @(negedge MCLK);
        d = 8'($urandom);
        sb[a] = d;
        run_cycle(OP_WR, a, d, CYC, 1);
        for (int k = 1; k <= CYC; k++) begin
            n_checks++;
            if (obs_v[k] !== exp_v(k, OP_WR, a)) begin
                n_fail++; $display("FAIL rearm k=%0d got=%h exp=%h", k, obs_v[k], exp_v(k, OP_WR, a));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] a;
        logic [7:0]  d;
        logic [27:0] got, exp;
        a = 16'h4321; d = 8'($urandom);
        sb[a] = d;
        wr_req = 1; wr_addr = a; wr_data = d;
        repeat (4) @(negedge MCLK);
        n_checks++;
        if ({RAS, CAS, WE} !== 3'b000) begin n_fail++; $display("FAIL mid_col got=%b exp=000", {RAS, CAS, WE}); end
        reset = 1;
        #1;
        got = {RAS, CAS, WE, OE, RD_d, AD, RD_o, rd_data, busy, wr_ack, 2'b00};
        exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mid_reset got=%h exp=%h", got, exp); end
        wr_req = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge MCLK);
            n_checks++;
            if ({wr_ack, busy, rd_data} !== 10'h000) begin
                n_fail++; $display("FAIL mid_reset_hold k=%0d got=%h exp=000", k, {wr_ack, busy, rd_data});
            end
        end
        reset = 0;
        d = 8'($urandom);
        sb[a] = d;
        run_cycle(OP_WR, a, d, CYC, 1);
        for (int k = 1; k <= CYC; k++) begin
            n_checks++;
            if (obs_v[k] !== exp_v(k, OP_WR, a)) begin
                n_fail++; $display("FAIL post_reset_wr k=%0d got=%h exp=%h", k, obs_v[k], exp_v(k, OP_WR, a));
            end
        end
        run_cycle(OP_RD, a, 8'h00, CYC, 1);
        n_checks++;
        if (obs_rdd[KACK] !== d) begin n_fail++; $display("FAIL post_reset_rd got=%h exp=%h", obs_rdd[KACK], d); end
    endtask

    task automatic test_random();
        logic [15:0] pool [6];
        logic [15:0] a;
        logic [7:0]  d, er;
        tb_op_t      op;
        int unsigned r;
        for (int i = 0; i < 6; i++) pool[i] = 16'($urandom);
        for (int n = 0; n < 30; n++) begin
            r  = $urandom_range(0, 9);
            op = (r < 4) ? OP_WR : (r < 8) ? OP_RD : OP_XF;
            a  = pool[$urandom_range(0, 5)];
            d  = 8'($urandom);
            er = sb_rd(a);
            if (op == OP_WR) sb[a] = d;
            run_cycle(op, a, d, CYC, 1);
            for (int k = 1; k <= CYC; k++) begin
                n_checks++;
                if (obs_v[k] !== exp_v(k, op, a)) begin
                    n_fail++; $display("FAIL random n=%0d k=%0d got=%h exp=%h", n, k, obs_v[k], exp_v(k, op, a));
                end
            end
            if (op == OP_RD) begin
                n_checks++;
                if (obs_rdd[KACK] !== er) begin
                    n_fail++; $display("FAIL random_rd n=%0d got=%h exp=%h", n, obs_rdd[KACK], er);
                end
            end
            if (op == OP_WR) begin
                for (int k = 3; k <= 2 + TCAS; k++) begin
                    n_checks++;
                    if (obs_rdo[k] !== d) begin
                        n_fail++; $display("FAIL random_rdo n=%0d k=%0d got=%h exp=%h", n, k, obs_rdo[k], d);
                    end
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge MCLK);
        end
    endtask

    task automatic test_sc_hold();
        logic e;
        sc_step = 1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge MCLK);
            e = (k <= 4) ? ((k % 2) == 1) : 1'b0;
            n_checks++;
            if (SC !== e) begin n_fail++; $display("FAIL sc_hold k=%0d got=%b exp=%b", k, SC, e); end
            if (k == 4) sc_step = 0;
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_back();
        test_priority();
        test_serial();
        test_write_lockout();
        test_reset_mid();
        test_random();
        test_sc_hold();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_ctrl.md
VRAM_CTRL -- requirements
Module: vram_ctrl

Interface
REQ-001 Parameter TCAS, default 3: MCLK cycles per column phase; legal range 2..7.
REQ-002 Parameter TPRE, default 2: MCLK cycles per precharge phase; legal range 1..7.
REQ-003 MCLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 xfer_req  in  1, xfer_addr  in  16: read-transfer request and address; level held until xfer_ack.
REQ-006 rd_req  in  1, rd_addr  in  16: byte-read request and address; level held until rd_ack.
REQ-007 wr_req  in  1, wr_addr  in  16, wr_data  in  8: byte-write request, address and data; level held until wr_ack.
REQ-008 xfer_ack, rd_ack, wr_ack  out  1 each: one-cycle completion pulses.
REQ-009 rd_data  out  8: byte captured by the last read cycle.
REQ-010 sc_step  in  1, ser_en  in  1: serial-advance pulse and serial output enable.
REQ-011 busy  out  1: high whenever state is not IDLE.
REQ-012 RAS, CAS, WE, OE, SC, SE  out  1 each: VRAM strobes; RAS, CAS, WE and OE are active-low.
REQ-013 AD  out  8: multiplexed row/column address to VRAM.
REQ-014 RD_o  out  8, RD_d  out  1: write data to VRAM RD_i and drive-disable (1 = not driving).
REQ-015 RD_i  in  8: read data from VRAM RD_o.

Function
REQ-016 States SHALL be IDLE, ROW (2 cycles), COL (TCAS cycles) and PRE (TPRE cycles), with a 3-bit phase counter.
REQ-017 In IDLE, arbitration SHALL use fixed priority xfer > rd > wr; the winner's address, data and type are latched and the next state is ROW.
REQ-018 Requests SHALL be sampled only in IDLE; a request arriving mid-cycle waits for the next IDLE.
REQ-019 In IDLE and PRE: RAS=CAS=WE=OE=1, RD_d=1, AD=0.
REQ-020 In ROW: RAS=0, CAS=1, AD=addr[15:8], held for both cycles; OE=0 for a transfer, otherwise 1.
REQ-021 In COL: RAS=0, CAS=0, AD=addr[7:0].
REQ-022 COL read: OE=0.
REQ-023 COL write: WE=0, RD_o=wr_data and RD_d=0 for every COL cycle.
REQ-024 COL transfer: OE=0 and WE=1; OE rises on PRE entry, which is the transfer trigger.
REQ-025 For a read, rd_data SHALL load RD_i on the final COL edge and hold it until the next read.
REQ-026 The matching ack SHALL pulse during the first PRE cycle.
REQ-027 PRE SHALL always return to IDLE, so the minimum cycle period is 3+TCAS+TPRE MCLK cycles (8 at defaults).
REQ-028 Latency: req high at IDLE edge N -> ROW at N+1 and N+2, COL at N+3..N+2+TCAS, ack at N+3+TCAS (6 at defaults).
REQ-029 A request dropped mid-cycle SHALL NOT abort the cycle; the cycle completes and the ack still pulses.
REQ-030 Serial clock: on an sc_step pulse while SC=0, SC=1 for one cycle, then 0; sc_step while SC=1 is ignored; SC runs independently of the main FSM.
REQ-031 SE SHALL equal ~ser_en, registered.
REQ-032 A write request holding its address across cycles SHALL be re-served only after its ack has been observed and the request reasserted.

Reset
REQ-033 While reset=1: state=IDLE, RAS=CAS=WE=OE=1, SC=0, SE=1, RD_d=1, AD=0, RD_o=0, rd_data=0, acks=0, busy=0.
REQ-034 Reset asserted mid-cycle SHALL release all strobes immediately, with no ack and no rd_data update.
REQ-035 After reset deassertion, the first arbitration SHALL occur on the first MCLK edge.

Verification
REQ-036 wr_req, wr_addr=0x1234, wr_data=0xA5 -> AD=0x12 for 2 cycles with RAS=0, then AD=0x34 with CAS=0, WE=0 and RD_o=0xA5 for 3 cycles; wr_ack 6 cycles after the request.
REQ-037 Read back 0x1234 using a VRAM model -> OE=0 during COL only; rd_data=0xA5 and rd_ack in the first PRE cycle.
REQ-038 xfer_req and rd_req asserted in the same cycle -> transfer served first (OE=0 from ROW onward, rising on PRE entry), read served in the next cycle; acks 8 cycles apart.
REQ-039 xfer with addr=0x0102, then sc_step pulses every 2 cycles and ser_en=1 -> SC pulses are 1 cycle wide, SE=0, and the VRAM model outputs bytes at offsets 2, 3, 0, 1 in sequence.
REQ-040 reset asserted during the second COL cycle of a write -> all strobes high in the same cycle, no wr_ack, busy=0; a new write after release completes normally.
REQ-041 sc_step held high for 4 cycles -> SC toggles 1,0,1,0, never high on consecutive cycles.
